// File: rtl/lcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lcd_pkg                                                    |
// | Description : Shared types and constants for the HD44780 4-bit writer:   |
// |               FSM state encoding, wait selectors, power-on init ROM,     |
// |               command constants and timer helpers.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package lcd_pkg;

  // Down-counter width; covers the largest default delay (T_CLEAR / T_POWERUP).
  localparam int TIMER_W  = 20;
  localparam int INIT_LEN = 8;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_FUNCSET = 8'h28;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DISPON  = 8'h0C;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_IDLE     = 3'd2,
    ST_SETUP    = 3'd3,
    ST_E_HIGH   = 3'd4,
    ST_HOLD     = 3'd5,
    ST_GAP      = 3'd6,
    ST_WAIT     = 3'd7
  } lcd_state_e;

  typedef enum logic [1:0] {
    WS_INIT1 = 2'd0,
    WS_INIT2 = 2'd1,
    WS_EXEC  = 2'd2,
    WS_CLEAR = 2'd3
  } wait_sel_e;

  // Single-nibble entries carry their nibble in value[7:4].
  typedef struct packed {
    logic [7:0] value;
    logic       single;
    wait_sel_e  wsel;
  } init_entry_t;

  function automatic init_entry_t init_rom(input logic [2:0] idx);
    init_entry_t e;
    case (idx)
      3'd0:    e = '{value: 8'h30,       single: 1'b1, wsel: WS_INIT1};
      3'd1:    e = '{value: 8'h30,       single: 1'b1, wsel: WS_INIT2};
      3'd2:    e = '{value: 8'h30,       single: 1'b1, wsel: WS_EXEC};
      3'd3:    e = '{value: 8'h20,       single: 1'b1, wsel: WS_EXEC};
      3'd4:    e = '{value: CMD_FUNCSET, single: 1'b0, wsel: WS_EXEC};
      3'd5:    e = '{value: CMD_ENTRY,   single: 1'b0, wsel: WS_EXEC};
      3'd6:    e = '{value: CMD_DISPON,  single: 1'b0, wsel: WS_EXEC};
      default: e = '{value: CMD_CLEAR,   single: 1'b0, wsel: WS_CLEAR};
    endcase
    return e;
  endfunction

  // Clear and return-home are the slow commands.
  function automatic logic needs_clear_wait(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

  // A delay of n cycles is loaded as n-1; the state leaves when the count hits 0.
  function automatic logic [TIMER_W-1:0] load_value(input int unsigned n);
    return TIMER_W'(n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_delay_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lcd_delay_timer                                            |
// | Description : Loadable down-counter with zero flag, shared by every wait |
// |               in the LCD writer. Holds at zero until reloaded.           |
// | Ports       : clk_i      clock                                           |
// |               rst_i      synchronous active-high reset (count -> 0)      |
// |               load_i     load load_val_i this cycle                      |
// |               load_val_i value to load                                   |
// |               zero_o     count is zero                                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lcd_delay_timer
  import lcd_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_4bit_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lcd_4bit_writer                                            |
// | Description : HD44780 4-bit-mode byte writer. Runs the power-on init     |
// |               sequence, then sends one byte per valid/ready handshake as |
// |               two E-strobed nibbles followed by the execution delay.     |
// | Ports       : qzt_clk   50 MHz clock                                     |
// |               reset     synchronous active-high reset                    |
// |               in_data   byte to send                                     |
// |               in_rs     0 = command, 1 = character data                  |
// |               in_valid  byte offered                                     |
// |               in_ready  byte accepted this cycle if in_valid             |
// |               init_done init finished; sticky until reset                |
// |               lcd_flags {LCD_RS, LCD_E}                                  |
// |               lcd_data  LCD_DB[7:4]                                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lcd_4bit_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EPULSE  = 12,
  parameter int unsigned T_HOLD    = 1,
  parameter int unsigned T_GAP     = 50,
  parameter int unsigned T_EXEC    = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       init_done,
  output logic [1:0] lcd_flags,
  output logic [3:0] lcd_data
);

  lcd_state_e         state_q, state_d;
  logic [2:0]         idx_q, idx_d;          // init ROM pointer
  logic [7:0]         byte_q, byte_d;        // byte being sent
  logic               rs_q, rs_d;
  logic [3:0]         data_q, data_d;        // nibble on the bus
  logic               nib_lo_q, nib_lo_d;    // 1 while sending the low nibble
  logic               armed_q, armed_d;      // power-up delay has been loaded
  logic               init_done_q, init_done_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_zero;

  init_entry_t        rom_entry;
  wait_sel_e          wait_sel;
  logic [TIMER_W-1:0] wait_ticks;
  logic               last_nibble;

  lcd_delay_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk_i      (qzt_clk),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign rom_entry = init_rom(idx_q);

  // During init the ROM chooses the wait; afterwards it depends on the byte.
  always_comb begin
    wait_sel = WS_EXEC;
    if (!init_done_q) begin
      wait_sel = rom_entry.wsel;
    end else if (needs_clear_wait(rs_q, byte_q)) begin
      wait_sel = WS_CLEAR;
    end
  end

  always_comb begin
    wait_ticks = load_value(T_EXEC);
    case (wait_sel)
      WS_INIT1: wait_ticks = load_value(T_INIT1);
      WS_INIT2: wait_ticks = load_value(T_INIT2);
      WS_CLEAR: wait_ticks = load_value(T_CLEAR);
      default:  wait_ticks = load_value(T_EXEC);
    endcase
  end

  // Init entries 0-3 are a lone high nibble, so they skip GAP and the low half.
  assign last_nibble = nib_lo_q || (!init_done_q && rom_entry.single);

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_q     <= ST_PWR_WAIT;
      idx_q       <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      nib_lo_q    <= 1'b0;
      armed_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      nib_lo_q    <= nib_lo_d;
      armed_q     <= armed_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    data_d      = data_q;
    nib_lo_d    = nib_lo_q;
    armed_d     = armed_q;
    init_done_d = init_done_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      ST_PWR_WAIT: begin
        // Reset leaves the timer at zero, so the power-up delay is loaded
        // on the first cycle out of reset.
        if (!armed_q) begin
          armed_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = load_value(T_POWERUP);
        end else if (tmr_zero) begin
          state_d = ST_INIT;
        end
      end

      ST_INIT: begin
        byte_d   = rom_entry.value;
        rs_d     = 1'b0;
        nib_lo_d = 1'b0;
        data_d   = rom_entry.value[7:4];
        state_d  = ST_SETUP;
        tmr_load = 1'b1;
        tmr_val  = load_value(T_SETUP);
      end

      ST_IDLE: begin
        if (in_valid && init_done_q) begin
          byte_d   = in_data;
          rs_d     = in_rs;
          nib_lo_d = 1'b0;
          data_d   = in_data[7:4];
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = load_value(T_SETUP);
        end
      end

      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_E_HIGH;
          tmr_load = 1'b1;
          tmr_val  = load_value(T_EPULSE);
        end
      end

      ST_E_HIGH: begin
        if (tmr_zero) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = load_value(T_HOLD);
        end
      end

      ST_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (last_nibble) begin
            state_d = ST_WAIT;
            tmr_val = wait_ticks;
          end else begin
            state_d = ST_GAP;
            tmr_val = load_value(T_GAP);
          end
        end
      end

      ST_GAP: begin
        // The low nibble goes on the bus while E is low, ahead of SETUP.
        if (tmr_zero) begin
          nib_lo_d = 1'b1;
          data_d   = byte_q[3:0];
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = load_value(T_SETUP);
        end
      end

      ST_WAIT: begin
        if (tmr_zero) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == 3'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_INIT;
          end
        end
      end

      default: begin
        state_d = ST_PWR_WAIT;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) && init_done_q;
  assign init_done = init_done_q;
  assign lcd_flags = {rs_q, (state_q == ST_E_HIGH)};
  assign lcd_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_4bit_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lcd_4bit_writer                                         |
// | Description : Scoreboard bench for lcd_4bit_writer. Expected nibbles are |
// |               queued when stimulus is driven and popped on each E rise.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_lcd_4bit_writer;

  localparam int T_POWERUP = 20;
  localparam int T_SETUP   = 2;
  localparam int T_EPULSE  = 3;
  localparam int T_HOLD    = 1;
  localparam int T_GAP     = 4;
  localparam int T_EXEC    = 8;
  localparam int T_CLEAR   = 30;
  localparam int T_INIT1   = 10;
  localparam int T_INIT2   = 5;

  // Accept edge to in_ready high, excluding the post-byte wait.
  localparam int LAT_BASE = T_SETUP + T_EPULSE + T_HOLD + T_GAP
                          + T_SETUP + T_EPULSE + T_HOLD;

  logic       qzt_clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_rs;
  logic       in_valid;
  logic       in_ready;
  logic       init_done;
  logic [1:0] lcd_flags;
  logic [3:0] lcd_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_sent = 0;

  logic [4:0] exp_q[$];   // {rs, nibble}
  logic       e_prev = 1'b0;
  int         e_width = 0;
  logic [4:0] held;

  always #5 qzt_clk = ~qzt_clk;

  lcd_4bit_writer #(
    .T_POWERUP (T_POWERUP),
    .T_SETUP   (T_SETUP),
    .T_EPULSE  (T_EPULSE),
    .T_HOLD    (T_HOLD),
    .T_GAP     (T_GAP),
    .T_EXEC    (T_EXEC),
    .T_CLEAR   (T_CLEAR),
    .T_INIT1   (T_INIT1),
    .T_INIT2   (T_INIT2)
  ) dut (
    .qzt_clk   (qzt_clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_rs     (in_rs),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .init_done (init_done),
    .lcd_flags (lcd_flags),
    .lcd_data  (lcd_data)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Nibble monitor and bus-protocol checks, sampled mid-cycle.
  always @(negedge qzt_clk) begin
    check("ready_before_init", {31'd0, in_ready & ~init_done}, 32'd0);
    if (in_valid && in_ready) n_acc++;
    if (lcd_flags[0] && !e_prev) begin
      check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("nibble", {27'd0, lcd_flags[1], lcd_data}, {27'd0, exp_q.pop_front()});
      held    = {lcd_flags[1], lcd_data};
      e_width = 1;
    end else if (lcd_flags[0]) begin
      e_width++;
      check("e_stable", {27'd0, lcd_flags[1], lcd_data}, {27'd0, held});
    end else if (e_prev && !reset) begin
      check("e_width", e_width, T_EPULSE);
    end
    e_prev = lcd_flags[0];
  end

  function automatic int exp_latency(input logic [7:0] b, input logic rs);
    if (!rs && (b == 8'h01 || b == 8'h02)) return LAT_BASE + T_CLEAR;
    return LAT_BASE + T_EXEC;
  endfunction

  task automatic push_byte(input logic [7:0] b, input logic rs);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  task automatic push_init();
    logic [3:0] seq[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, seq[i]});
  endtask

  // Called #1 after a rising edge; counts edges until in_ready is seen high.
  task automatic wait_ready_cnt(output int cyc);
    cyc = 0;
    while (!in_ready && cyc < 2000) begin
      @(posedge qzt_clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_init(input string tag);
    int c;
    c = 0;
    while (!init_done && c < 5000) begin
      @(posedge qzt_clk);
      #1;
      c++;
    end
    check({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
    check({tag, "_init_sb_empty"}, exp_q.size(), 32'd0);
    check({tag, "_ready_after_init"}, {31'd0, in_ready}, 32'd1);
  endtask

  // keep=1 leaves in_valid high so the next call's byte queues behind this one.
  task automatic send_byte(input logic [7:0] b, input logic rs, input logic keep);
    int c;
    push_byte(b, rs);
    in_data  = b;
    in_rs    = rs;
    in_valid = 1'b1;
    wait_ready_cnt(c);
    @(posedge qzt_clk);
    n_sent++;
    #1;
    if (!keep) in_valid = 1'b0;
    in_data = 8'($urandom);
    in_rs   = 1'($urandom);
    check("ready_low_after_accept", {31'd0, in_ready}, 32'd0);
    wait_ready_cnt(c);
    check($sformatf("latency_%02h_rs%0d", b, rs), c, exp_latency(b, rs));
  endtask

  initial begin
    int c;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_rs    = 1'b0;
    repeat (2) @(posedge qzt_clk);
    #1;
    check("rst_flags", {30'd0, lcd_flags}, 32'd0);
    check("rst_data", {28'd0, lcd_data}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);

    push_init();
    reset = 1'b0;
    wait_init("first");

    send_byte(8'h41, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);

    // Three bytes offered back to back with in_valid never dropping.
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'h28, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b0);

    // Reset in the middle of a byte, while E is high.
    push_byte(8'h7E, 1'b1);
    in_data  = 8'h7E;
    in_rs    = 1'b1;
    in_valid = 1'b1;
    @(posedge qzt_clk);
    n_sent++;
    #1;
    in_valid = 1'b0;
    c = 0;
    while (!lcd_flags[0] && c < 100) begin
      @(posedge qzt_clk);
      #1;
      c++;
    end
    check("midbyte_e_high", {31'd0, lcd_flags[0]}, 32'd1);
    reset = 1'b1;
    @(posedge qzt_clk);
    #1;
    check("midrst_flags", {30'd0, lcd_flags}, 32'd0);
    check("midrst_data", {28'd0, lcd_data}, 32'd0);
    repeat (4) begin
      @(posedge qzt_clk);
      #1;
      check("midrst_ready", {31'd0, in_ready}, 32'd0);
      check("midrst_init_done", {31'd0, init_done}, 32'd0);
    end
    exp_q.delete();
    push_init();
    reset = 1'b0;
    wait_init("replay");

    send_byte(8'h5A, 1'b1, 1'b0);
    repeat (3) @(posedge qzt_clk);
    #1;
    check("accept_count", n_acc, n_sent);
    check("final_sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
